// File: rtl/result_uart_formatter_pkg.sv
// Shared types and constants for the result UART formatter.
package result_uart_formatter_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CONVERT     = 3'd1,
    SEND_RAW    = 3'd2,
    SEND_SIGN   = 3'd3,
    SEND_DIGITS = 3'd4,
    SEND_CR     = 3'd5,
    SEND_LF     = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Decimal digits needed to hold any unsigned value of the given bit width.
  function automatic int unsigned num_digits(input int unsigned width);
    return (width * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/result_uart_formatter_if.sv
// Result-in / byte-out bus between the coprocessor side and the formatter.
interface result_uart_formatter_if #(
  parameter int unsigned WIDTH_DIN = 16*8
);
  logic [WIDTH_DIN-1:0] din;
  logic                 din_valid;
  logic                 fmt;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;
  logic [7:0]           drop_count;

  modport master (
    output din, din_valid, fmt, tx_ready,
    input  tx_data, tx_valid, busy, drop_count
  );

  modport slave (
    input  din, din_valid, fmt, tx_ready,
    output tx_data, tx_valid, busy, drop_count
  );
endinterface

// File: rtl/result_uart_formatter_bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per cycle. The first step is
// folded into the load (adjusting an all-zero BCD is a no-op), so done_o rises
// WIDTH-1 cycles after start_i and bcd_o then holds until the next start.
module bin2bcd_seq
  import result_uart_formatter_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_DIGITS = num_digits(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        value_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next shift/adjust step, or a fresh load on start.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    adj_c  = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      bcd_d = {{(BCD_W-1){1'b0}}, value_i[WIDTH-1]};
      bin_d = value_i << 1;
      cnt_d = CNT_W'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj_c[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_d  = bin_q << 1;
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/result_uart_formatter.sv
// Formats a coprocessor result as raw big-endian bytes or as a signed decimal
// ASCII line (CR LF terminated) and streams it over a valid/ready byte port.
module result_uart_formatter
  import result_uart_formatter_pkg::*;
#(
  parameter int unsigned WIDTH_DIN     = 16*8,
  parameter int unsigned WIDTH_COMPUTE = 32
) (
  input logic                   clk,
  input logic                   rst,
  result_uart_formatter_if.slave bus
);

  localparam int unsigned NBYTES = WIDTH_DIN / 8;
  localparam int unsigned BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned ND     = num_digits(WIDTH_COMPUTE);
  localparam int unsigned IDXW   = (ND > 1) ? $clog2(ND) : 1;

  state_t               state_q, state_d;
  logic [WIDTH_DIN-1:0] raw_q, raw_d, raw_shift_c;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                 neg_q, neg_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic [7:0]           drop_q, drop_d;

  logic [WIDTH_COMPUTE-1:0] x_c, mag_c;
  logic                     start_c, done_c, xfer_c;
  logic [4*ND-1:0]          bcd_c;
  logic [IDXW-1:0]          msd_c;
  logic [3:0]               msd_digit_c, cur_digit_c, next_digit_c;

  // Magnitude of the signed field; -2^(W-1) maps onto 2^(W-1) unsigned.
  always_comb begin
    x_c   = bus.din[WIDTH_COMPUTE-1:0];
    mag_c = x_c[WIDTH_COMPUTE-1] ? (~x_c + WIDTH_COMPUTE'(1)) : x_c;
  end

  bin2bcd_seq #(
    .WIDTH      (WIDTH_COMPUTE),
    .NUM_DIGITS (ND)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_c),
    .value_i (mag_c),
    .done_o  (done_c),
    .bcd_o   (bcd_c)
  );

  // Digit lookup: leading nonzero digit (ones digit if all zero) and the
  // digits at/below the current emit index.
  always_comb begin
    msd_c        = '0;
    msd_digit_c  = '0;
    cur_digit_c  = '0;
    next_digit_c = '0;
    for (int i = 0; i < int'(ND); i++) begin
      if (bcd_c[4*i +: 4] != 4'd0) begin
        msd_c       = IDXW'(i);
        msd_digit_c = bcd_c[4*i +: 4];
      end
      if (IDXW'(i) == idx_q)              cur_digit_c  = bcd_c[4*i +: 4];
      if (IDXW'(i) == idx_q - IDXW'(1))   next_digit_c = bcd_c[4*i +: 4];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    raw_d       = raw_q;
    byte_cnt_d  = byte_cnt_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    drop_d      = drop_q;
    start_c     = 1'b0;
    xfer_c      = tx_valid_q & bus.tx_ready;
    raw_shift_c = raw_q << 8;

    if (bus.din_valid && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          if (!bus.fmt) begin
            state_d    = SEND_RAW;
            raw_d      = bus.din;
            byte_cnt_d = BCW'(NBYTES - 1);
            tx_data_d  = bus.din[WIDTH_DIN-1 -: 8];
            tx_valid_d = 1'b1;
          end else begin
            state_d = CONVERT;
            neg_d   = x_c[WIDTH_COMPUTE-1];
            start_c = 1'b1;
          end
        end
      end
      CONVERT: begin
        if (done_c) begin
          tx_valid_d = 1'b1;
          idx_d      = msd_c;
          if (neg_q) begin
            state_d   = SEND_SIGN;
            tx_data_d = ASCII_MINUS;
          end else begin
            state_d   = SEND_DIGITS;
            tx_data_d = ASCII_ZERO | {4'h0, msd_digit_c};
          end
        end
      end
      SEND_RAW: begin
        if (xfer_c) begin
          if (byte_cnt_q == '0) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end else begin
            raw_d      = raw_shift_c;
            byte_cnt_d = byte_cnt_q - BCW'(1);
            tx_data_d  = raw_shift_c[WIDTH_DIN-1 -: 8];
          end
        end
      end
      SEND_SIGN: begin
        if (xfer_c) begin
          state_d   = SEND_DIGITS;
          tx_data_d = ASCII_ZERO | {4'h0, cur_digit_c};
        end
      end
      SEND_DIGITS: begin
        if (xfer_c) begin
          if (idx_q == '0) begin
            state_d   = SEND_CR;
            tx_data_d = ASCII_CR;
          end else begin
            idx_d     = idx_q - IDXW'(1);
            tx_data_d = ASCII_ZERO | {4'h0, next_digit_c};
          end
        end
      end
      SEND_CR: begin
        if (xfer_c) begin
          state_d   = SEND_LF;
          tx_data_d = ASCII_LF;
        end
      end
      SEND_LF: begin
        if (xfer_c) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over any same-cycle din_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      raw_q      <= '0;
      byte_cnt_q <= '0;
      neg_q      <= 1'b0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      raw_q      <= raw_d;
      byte_cnt_q <= byte_cnt_d;
      neg_q      <= neg_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_result_uart_formatter.sv
// Directed bench for result_uart_formatter: raw and decimal messages, timing,
// backpressure, drop counting and mid-message reset.
module tb_result_uart_formatter;

  localparam int unsigned WIDTH_DIN     = 128;
  localparam int unsigned WIDTH_COMPUTE = 32;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  result_uart_formatter_if #(.WIDTH_DIN(WIDTH_DIN)) bus ();

  result_uart_formatter #(
    .WIDTH_DIN     (WIDTH_DIN),
    .WIDTH_COMPUTE (WIDTH_COMPUTE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH_DIN-1:0] d, input logic f);
    bus.din       = d;
    bus.fmt       = f;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  function automatic bq_t line(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  // Drain one message, optionally with random tx_ready, and check it.
  task automatic collect(input string tag, input bq_t exp, input bit rand_ready);
    bq_t         got;
    int unsigned viol = 0;
    int unsigned cyc  = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [7:0]  pd = 8'h00;
    logic [31:0] obs;
    while (got.size() < exp.size() && cyc < 2000) begin
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr && (bus.tx_valid !== 1'b1 || bus.tx_data !== pd)) viol++;
      if (bus.tx_valid === 1'b1 && bus.tx_ready) got.push_back(bus.tx_data);
      pv = bus.tx_valid;
      pr = bus.tx_ready;
      pd = bus.tx_data;
      tick();
      cyc++;
    end
    bus.tx_ready = 1'b0;
    chk({tag, " len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      obs = (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD;
      chk($sformatf("%s byte%0d", tag, i), obs, {24'h0, exp[i]});
    end
    if (rand_ready) chk({tag, " stall_stable"}, viol, 32'd0);
    chk({tag, " busy_after"}, {31'h0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [WIDTH_DIN-1:0] d;
    bq_t                  q;
    int unsigned          early;

    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.fmt       = 1'b0;
    bus.tx_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset tx_valid", {31'h0, bus.tx_valid}, 32'd0);
    chk("reset tx_data", {24'h0, bus.tx_data}, 32'd0);
    chk("reset busy", {31'h0, bus.busy}, 32'd0);
    chk("reset drop", {24'h0, bus.drop_count}, 32'd0);

    // Raw mode: 00..0F on 16 back-to-back cycles from N+1.
    for (int i = 0; i < 16; i++) d[WIDTH_DIN-1-8*i -: 8] = 8'(i);
    bus.tx_ready = 1'b1;
    send(d, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("raw valid%0d", i), {31'h0, bus.tx_valid}, 32'd1);
      chk($sformatf("raw byte%0d", i), {24'h0, bus.tx_data}, 32'(i));
      tick();
    end
    chk("raw busy_after", {31'h0, bus.busy}, 32'd0);
    chk("raw valid_after", {31'h0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;

    // Decimal 1234: tx_ready low during conversion, first byte at N+33.
    send({96'h0, 32'd1234}, 1'b1);
    early = 0;
    for (int c = 1; c < 32; c++) begin
      if (bus.tx_valid !== 1'b0) early++;
      tick();
    end
    chk("dec1234 no_early_valid", early, 32'd0);
    chk("dec1234 N+32 valid", {31'h0, bus.tx_valid}, 32'd0);
    chk("dec1234 N+32 busy", {31'h0, bus.busy}, 32'd1);
    tick();
    chk("dec1234 N+33 valid", {31'h0, bus.tx_valid}, 32'd1);
    chk("dec1234 N+33 data", {24'h0, bus.tx_data}, 32'h31);
    collect("dec1234", line("1234"), 1'b0);

    // Decimal boundaries; upper din bits must be ignored.
    send({96'hABC, 32'h0000_0000}, 1'b1);
    collect("dec0", line("0"), 1'b0);
    send({96'h123, 32'hFFFF_FFFF}, 1'b1);
    collect("decm1", line("-1"), 1'b0);
    send({96'h0, 32'h8000_0000}, 1'b1);
    collect("decmin", line("-2147483648"), 1'b0);

    // Random backpressure on both formats.
    send({96'h0, 32'hFFFF_FB2E}, 1'b1);
    collect("rnd_dec", line("-1234"), 1'b1);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    send(d, 1'b0);
    collect("rnd_raw", q, 1'b1);

    // Three pulses while busy are dropped; a pulse in IDLE right after is taken.
    send({96'h0, 32'd1234}, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send({96'h0, 32'd77}, 1'b0);
      tick();
    end
    collect("drop msg", line("1234"), 1'b0);
    chk("drop count3", {24'h0, bus.drop_count}, 32'd3);
    send({96'h0, 32'd905}, 1'b1);
    collect("after_drop", line("905"), 1'b0);
    chk("drop count_hold", {24'h0, bus.drop_count}, 32'd3);

    // Reset in the middle of SEND_DIGITS.
    send({96'h0, 32'd1234}, 1'b1);
    early = 0;
    while (bus.tx_valid !== 1'b1 && early < 100) begin
      tick();
      early++;
    end
    chk("rstmid reached_send", {31'h0, bus.tx_valid}, 32'd1);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    chk("rstmid second_digit", {24'h0, bus.tx_data}, 32'h32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid tx_valid", {31'h0, bus.tx_valid}, 32'd0);
    chk("rstmid busy", {31'h0, bus.busy}, 32'd0);
    chk("rstmid tx_data", {24'h0, bus.tx_data}, 32'd0);
    chk("rstmid drop", {24'h0, bus.drop_count}, 32'd0);
    send({96'h0, 32'hFFFF_FFFF}, 1'b1);
    collect("rstmid next", line("-1"), 1'b0);

    // Reset and din_valid together: no capture.
    rst           = 1'b1;
    bus.din       = {96'h0, 32'd5};
    bus.fmt       = 1'b0;
    bus.din_valid = 1'b1;
    tick();
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    chk("rst_prio busy", {31'h0, bus.busy}, 32'd0);
    tick();
    chk("rst_prio valid", {31'h0, bus.tx_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_uart_formatter.md
RESULT_UART_FORMATTER -- requirements
Module: result_uart_formatter

Interface
REQ-001 SHALL have parameter WIDTH_DIN, default 16*8, meaning the width of the result word from the coprocessor.
REQ-002 SHALL have parameter WIDTH_COMPUTE, default 32, meaning the signed field width rendered in decimal mode.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port din, input, WIDTH_DIN: the result word, sampled only on acceptance.
REQ-006 SHALL have port din_valid, input, 1: a single-cycle pulse offering din.
REQ-007 SHALL have port fmt, input, 1: 0 selects raw-binary output, 1 selects decimal ASCII output; sampled on acceptance.
REQ-008 SHALL have port tx_data, output, 8: the byte offered to the UART transmitter.
REQ-009 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1: the transmitter accepts a byte in any cycle where tx_valid and tx_ready are both high.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-012 SHALL have port drop_count, output, 8: number of din_valid pulses ignored while busy.

Function
REQ-013 SHALL implement the states IDLE, CONVERT, SEND_RAW, SEND_SIGN, SEND_DIGITS, SEND_CR and SEND_LF.
REQ-014 SHALL accept din only in IDLE with din_valid=1, capturing din and fmt in the same cycle N.
REQ-015 SHALL, when fmt=0, enter SEND_RAW with tx_valid=1 at N+1, sending WIDTH_DIN/8 bytes MSB-first, din[WIDTH_DIN-1 -: 8] first, then return to IDLE.
REQ-016 SHALL, when fmt=1, take din[WIDTH_COMPUTE-1:0] as two's complement, record the sign, and convert magnitude = (negative ? ~x+1 : x) as a WIDTH_COMPUTE-bit unsigned value.
REQ-017 SHALL perform CONVERT as sequential double-dabble for exactly WIDTH_COMPUTE cycles (N+1..N+32 at default), with tx_valid=1 at N+33.
REQ-018 SHALL emit, in decimal mode, '-' (0x2D) only if negative, then decimal digits most-significant first with leading zeros suppressed, then 0x0D, then 0x0A.
REQ-019 SHALL emit a value of zero as the single digit '0' (0x30).
REQ-020 SHALL render -2147483648 (0x80000000) as "-2147483648", with magnitude 2147483648 and no overflow.
REQ-021 SHALL hold tx_data stable and tx_valid high until a transfer occurs, advancing exactly one byte per transfer.
REQ-022 SHALL permit back-to-back transfers with tx_ready held high, giving one byte per cycle with no bubbles between bytes of one message.
REQ-023 SHALL, after the final byte (LF, or the last raw byte) transfers, drop tx_valid and return to IDLE in the next cycle; a new din_valid is accepted in that IDLE cycle.
REQ-024 SHALL ignore din_valid in any state other than IDLE, leave the in-flight message intact, and increment drop_count, saturating at 255.
REQ-025 SHALL not let tx_ready affect the CONVERT timing.

Reset
REQ-026 SHALL, on rst=1 at a clock edge in any state including mid-message, go to IDLE with tx_valid=0, tx_data=0, busy=0, drop_count=0, and internal registers cleared.
REQ-027 SHALL give rst priority over din_valid in the same cycle, so that no capture occurs.

Structure
REQ-028 SHALL place the state enum and the byte constants (ASCII_MINUS 0x2D, ASCII_ZERO 0x30, ASCII_CR 0x0D, ASCII_LF 0x0A) in a shared package.
REQ-029 SHALL split out one sub-module, bin2bcd_seq (start/done, WIDTH_COMPUTE in, 10 BCD digits out at default width), that implements the double dabble.

Verification
REQ-030 SHALL cover: fmt=0, din=128'h000102...0F, tx_ready=1 -> bytes 0x00..0x0F on 16 consecutive cycles starting N+1, then busy=0.
REQ-031 SHALL cover: fmt=1, din[31:0]=1234 -> "1234\r\n" (31 32 33 34 0D 0A), first byte at N+33.
REQ-032 SHALL cover: fmt=1 with din[31:0]=0, -1, and 0x80000000 -> "0\r\n", "-1\r\n", and "-2147483648\r\n" respectively.
REQ-033 SHALL cover: tx_ready toggled pseudo-randomly -> identical byte sequence, with tx_data never changing while tx_valid=1 and tx_ready=0.
REQ-034 SHALL cover: three din_valid pulses while busy -> message unchanged and drop_count=3, with a fourth pulse after IDLE accepted.
REQ-035 SHALL cover: rst asserted mid SEND_DIGITS -> next cycle tx_valid=0 and busy=0, and a following message is output correctly.
